// File: rtl/serial_deframer.sv
// Serial word deframer: start bit, LSB-first data, optional even parity, stop bit.
// Good words are offered on a valid/ready port; framing, parity and overflow faults are flagged.
module serial_deframer #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_bit;
  logic             stop_eval;
  logic             par_bad;
  logic             good_word;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      case (state)
        IDLE:   if (in) state_nxt = DATA;
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN) state_nxt = PARITY;
            else           state_nxt = STOP;
          end
        end
        PARITY: state_nxt = STOP;
        STOP:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Frame evaluation happens on the strobe that samples the stop bit.
  assign stop_eval = bit_en && (state == STOP);
  assign par_bad   = PARITY_EN && (par_bit != even_parity(shreg));
  assign good_word = stop_eval && !in && !par_bad;

  always_ff @(posedge clk) begin
    if (bit_en) begin
      case (state)
        IDLE:   bit_cnt <= '0;
        DATA: begin
          shreg   <= {in, shreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: par_bit <= in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= stop_eval && in;
      parity_err <= stop_eval && par_bad;
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (good_word) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          data_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
// Randomized scoreboard bench for serial_deframer: a frame-level model queues expected
// words and error pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_serial_deframer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bit_en = 1'b0;
  logic         din = 1'b0;
  logic         data_ready = 1'b1;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;
  logic         overflow;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  logic [W-1:0] exp_words[$];
  logic [1:0]   exp_errs[$];

  serial_deframer #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in(din),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every transfer and every error pulse against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid && data_ready) begin
        checks++;
        if (exp_words.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected: got 0x%0h expected none", data_out);
        end else begin
          logic [W-1:0] w;
          w = exp_words.pop_front();
          if (data_out !== w) begin
            failures++;
            $display("FAIL word: got 0x%0h expected 0x%0h", data_out, w);
          end
        end
      end
      if (frame_err || parity_err) begin
        checks++;
        if (exp_errs.size() == 0) begin
          failures++;
          $display("FAIL err_unexpected: got f=%0b p=%0b expected none", frame_err, parity_err);
        end else begin
          logic [1:0] e;
          e = exp_errs.pop_front();
          if ({frame_err, parity_err} !== e) begin
            failures++;
            $display("FAIL err: got f=%0b p=%0b expected f=%0b p=%0b",
                     frame_err, parity_err, e[1], e[0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  // One bit held for p cycles; the strobe lands on the last of them.
  task automatic drive_bit(input logic b, input int p);
    for (int k = 0; k < p; k++) begin
      din    = b;
      bit_en = (k == p - 1);
      tick();
    end
    bit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      din    = 1'b0;
      bit_en = ($urandom_range(0, 1) == 1);
      tick();
    end
    bit_en = 1'b0;
  endtask

  // Reference outcome of a frame assuming the consumer keeps up (ready=1).
  task automatic predict(input logic [W-1:0] word, input logic flip, input logic stop);
    if (stop)      exp_errs.push_back({1'b1, flip});
    else if (flip) exp_errs.push_back(2'b01);
    else           exp_words.push_back(word);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic flip, input logic stop,
                            input int p, input bit model);
    if (model) predict(word, flip, stop);
    busy_cnt = 0;
    drive_bit(1'b1, p);
    for (int i = 0; i < W; i++) drive_bit(word[i], p);
    drive_bit((^word) ^ flip, p);
    drive_bit(stop, p);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_valid", data_valid, 0);
    check("reset_data", data_out, 0);
    check("reset_busy", busy, 0);
    check("reset_errs", {frame_err, parity_err, overflow}, 0);
    rst = 1'b1;
    tick();

    // 1: clean frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1);
    check("t1_valid", data_valid, 1);
    check("t1_data", data_out, 8'hA5);
    tick();
    check("t1_valid_drop", data_valid, 0);

    // 2: bad parity
    send_frame(8'hA5, 1'b1, 1'b0, 1, 1);
    tick();
    check("t2_valid", data_valid, 0);
    check("t2_busy", busy, 0);

    // 3: stop bit 1, then recovery
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1);
    check("t3_valid", data_valid, 0);
    idle(3);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1);
    check("t3_data", data_out, 8'h3C);
    tick();

    // 4: overflow with consumer stalled
    check("t4_ovf_pre", overflow, 0);
    data_ready = 1'b0;
    exp_words.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1, 0);
    idle(2);
    send_frame(8'h22, 1'b0, 1'b0, 1, 0);
    tick();
    check("t4_data", data_out, 8'h11);
    check("t4_valid", data_valid, 1);
    check("t4_ovf", overflow, 1);
    data_ready = 1'b1;
    tick();
    check("t4_valid_after", data_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // 5: strobe every 4th cycle
    send_frame(8'h5A, 1'b0, 1'b0, 4, 1);
    check("t5_data", data_out, 8'h5A);
    check("t5_busy_span", busy_cnt, (W + 2) * 4);
    tick();

    // 6: reset mid-frame
    drive_bit(1'b1, 1);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_outs", {data_valid, frame_err, parity_err, overflow}, 0);
    check("t6_data", data_out, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1, 1);
    check("t6_frame", data_out, 8'h81);
    tick();

    // Random frames
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] w;
      logic f, s;
      w = W'($urandom);
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 9) == 0);
      send_frame(w, f, s, $urandom_range(1, 3), 1);
      idle($urandom_range(1, 4));
    end

    for (int k = 0; k < 50 && (exp_words.size() != 0 || exp_errs.size() != 0); k++) tick();
    check("drain_words", exp_words.size(), 0);
    check("drain_errs", exp_errs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
